sprite_rom_arbiter: RTL and testbench
=====================================

# sprite_rom_arbiter

Round-robin arbiter that shares the single sprite ROM read port between the game's sprite engines (player, obstacles, coins, background). It grants one requester at a time, holds the grant until that requester releases it, and drives the select code for the 2:1 mux tree in front of the ROM address port. It sits between the per-sprite fetch engines and the ROM/mux datapath in the pixel pipeline.

## Interface
- N_REQ, 4: number of requesters; legal range 2..8.
- SEL_W, 2: width of the select code; must equal ceil(log2(N_REQ)).
- MAX_BURST, 8: maximum consecutive grant cycles per ownership; used only when the burst limit is compiled in.
- CNT_W, 4: burst counter width; must hold MAX_BURST.

- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  level request per requester; bit i is requester i.
- grant  output  N_REQ  one-hot grant, registered; all-zero when no owner.
- sel  output  SEL_W  binary index of the current or most recent owner; drives the mux tree select.
- busy  output  1  high while any grant bit is high.
- timeout  output  1  one-cycle pulse when a grant is force-released; present only when the burst limit is compiled in.

## Operation
- States: IDLE, OWN, GAP.
- IDLE:
  - If any req bit is high, the requester picked by round-robin (search starts at last+1 and wraps modulo N_REQ) is granted.
  - Next state is OWN. grant, sel and busy update at the same edge. The burst counter loads 1.
- OWN:
  - Grant is held while req[owner] is high. The counter increments, saturating at MAX_BURST.
  - If req[owner] is sampled low, grant clears, last is set to owner, and next state is GAP.
- GAP:
  - Exactly one cycle with grant all-zero; sel holds its value. Next state is IDLE.
  - The gap guarantees the mux select never changes while a grant is active.
- Requests from non-owners in OWN or GAP are ignored until IDLE. No queueing is needed because req is level-based.
- Simultaneous requests in IDLE are resolved by round-robin only; there is no fixed priority beyond the pointer.
- A req pulse that drops before it is granted is lost. This is legal.
- Reset values:
  - grant=0, sel=0, busy=0, timeout=0.
  - State is IDLE, counter=0.
  - last=N_REQ-1, so requester 0 wins the first arbitration.
- Reset asserted mid-ownership clears the grant at that edge with no GAP cycle.

## Timing
- Request to grant: req sampled high in IDLE at edge t gives grant at t.
- From a req rise in GAP, grant comes at the earliest 2 edges later.
- Release: req[owner] low at edge t gives grant low at t. The next grant to another requester is at t+2 at the earliest.
- Minimum ownership is 1 cycle. Back-to-back handoff costs 2 cycles: the release edge plus GAP.
- sel is stable from the grant edge through the end of GAP.

## Configuration
- SPRITE_ARB_BURST_LIMIT_EN defined:
  - In OWN, when the counter equals MAX_BURST and req[owner] is still high, the grant is force-released and the state goes to GAP.
  - last is set to owner, and timeout pulses for one cycle at that edge.
  - The released owner is re-granted only after all other pending requesters, per the round-robin order.
- Undefined: there is no counter limit and no timeout port; ownership is unbounded.

## Structure
- Shared package sprite_arb_pkg holds:
  - the state encoding (IDLE, OWN, GAP);
  - the default N_REQ and MAX_BURST constants;
  - a function mapping one-hot to binary index.
- Sub-module rr_pick: combinational round-robin picker with inputs req and last, and outputs a one-hot winner and a valid flag. It is instantiated once.

## Test plan
- Reset, then req=4'b0110 → grant=4'b0010, sel=1 on the next edge; busy=1.
- Owner 1 drops req while req[2] stays high → grant=0 for 2 cycles (release edge plus GAP), then grant=4'b0100, sel=2.
- req=4'b1111 held, each owner releases after 3 cycles → grant order is 0,1,2,3,0; every handoff has exactly one all-zero GAP cycle.
- With SPRITE_ARB_BURST_LIMIT_EN and MAX_BURST=8, req=4'b0011 held constantly:
  - owner 0 is released after 8 grant cycles and timeout pulses once;
  - owner 1 is granted next.
- rst asserted during OWN with grant=4'b1000 → grant=0, sel=0 at that edge; after rst drops with req=4'b1001, requester 0 is granted first.
- Single 1-cycle req pulse on requester 3 arriving during GAP → no grant issued, and state returns to IDLE.

Source files
------------

// File: rtl/sprite_arb_pkg.sv
// Shared definitions for the sprite ROM arbiter.
//   - FSM state encoding (idle / own / gap)
//   - default requester count and burst limit
//   - one-hot to binary index helper
package sprite_arb_pkg;

    localparam int unsigned NReqDefault     = 4;
    localparam int unsigned MaxBurstDefault = 8;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StOwn  = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;

    // Accepts up to 8 requesters; callers zero-extend narrower vectors.
    function automatic int unsigned onehot_to_idx(input logic [7:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Search starts at last+1 and wraps modulo N_REQ; the first high req bit wins.
// Ports:
//   req   - level request vector
//   last  - index of the most recent owner
//   win   - one-hot winner (all-zero when nothing requested)
//   valid - high when win has a bit set
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic [N_REQ-1:0] win,
    output logic             valid
);

    always_comb begin
        win   = '0;
        valid = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            logic [SEL_W-1:0] idx;
            idx = SEL_W'((32'(last) + k) % N_REQ);
            if (!valid && req[idx]) begin
                win[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing the sprite ROM read port between sprite engines.
// A grant is held until its owner drops req, followed by one all-zero gap cycle
// so the mux select never moves under an active grant.
// Optional feature macro: SPRITE_ARB_BURST_LIMIT_EN (force-release after
// MAX_BURST grant cycles, pulses timeout).
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous active-high reset
//   req     - level request per requester
//   grant   - registered one-hot grant
//   sel     - index of current or most recent owner (mux select)
//   busy    - any grant bit high
//   timeout - one-cycle pulse on forced release (burst limit builds only)
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = NReqDefault,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned MAX_BURST = MaxBurstDefault,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
`ifdef SPRITE_ARB_BURST_LIMIT_EN
    output logic             timeout,
`endif
    output logic             busy
);

    logic [1:0]       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] pick_win;
    logic             pick_valid;
    logic             cnt_at_max;
`ifdef SPRITE_ARB_BURST_LIMIT_EN
    logic             timeout_q, timeout_d;
`endif

    rr_pick #(
        .N_REQ(N_REQ),
        .SEL_W(SEL_W)
    ) u_rr_pick (
        .req  (req),
        .last (last_q),
        .win  (pick_win),
        .valid(pick_valid)
    );

    assign cnt_at_max = (cnt_q == CNT_W'(MAX_BURST));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
`ifdef SPRITE_ARB_BURST_LIMIT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = pick_win;
                    sel_d   = SEL_W'(onehot_to_idx(8'(pick_win)));
                    cnt_d   = CNT_W'(1);
                    state_d = StOwn;
                end
            end
            StOwn: begin
                // sel_q is the owner index while in StOwn.
                if (!req[sel_q]) begin
                    grant_d = '0;
                    last_d  = sel_q;
                    state_d = StGap;
                end
`ifdef SPRITE_ARB_BURST_LIMIT_EN
                else if (cnt_at_max) begin
                    grant_d   = '0;
                    last_d    = sel_q;
                    state_d   = StGap;
                    timeout_d = 1'b1;
                end
`endif
                else if (!cnt_at_max) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= SEL_W'(N_REQ - 1);
            cnt_q   <= '0;
`ifdef SPRITE_ARB_BURST_LIMIT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
`ifdef SPRITE_ARB_BURST_LIMIT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = |grant_q;
`ifdef SPRITE_ARB_BURST_LIMIT_EN
    assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
module tb_sprite_rom_arbiter;

    localparam int N = 4;
    localparam int MAXB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
`ifdef SPRITE_ARB_BURST_LIMIT_EN
    logic       timeout;
`endif

    sprite_rom_arbiter #(
        .N_REQ    (4),
        .SEL_W    (2),
        .MAX_BURST(8),
        .CNT_W    (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .grant  (grant),
        .sel    (sel),
`ifdef SPRITE_ARB_BURST_LIMIT_EN
        .timeout(timeout),
`endif
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drive inputs away from the edge, then sample just after it.
    task automatic apply(input logic r, input logic [3:0] q);
        @(negedge clk);
        rst = r;
        req = q;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       r;
        logic [3:0] q;
        logic [3:0] g;
        int         s;
        logic       b;
    } vec_t;

    function automatic vec_t v(logic r, logic [3:0] q, logic [3:0] g, int s, logic b);
        vec_t x;
        x.r = r; x.q = q; x.g = g; x.s = s; x.b = b;
        return x;
    endfunction

    // Reference model: who owns the port, whether a gap is pending, who went last.
    int m_owner, m_last, m_sel, m_cnt;
    bit m_gap, m_to;

    task automatic model_step(input logic r, input logic [3:0] q);
        m_to = 0;
        if (r) begin
            m_owner = -1; m_gap = 0; m_last = N - 1; m_sel = 0; m_cnt = 0;
        end else if (m_gap) begin
            m_gap = 0;
        end else if (m_owner >= 0) begin
            bit limit_hit;
`ifdef SPRITE_ARB_BURST_LIMIT_EN
            limit_hit = (m_cnt == MAXB);
`else
            limit_hit = 0;
`endif
            if (!q[m_owner] || limit_hit) begin
                m_to = q[m_owner] && limit_hit;
                m_last = m_owner; m_owner = -1; m_gap = 1;
            end else if (m_cnt < MAXB) begin
                m_cnt++;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (q[i]) begin
                    m_owner = i; m_sel = i; m_cnt = 1;
                    break;
                end
            end
        end
    endtask

    initial begin
        vec_t tbl[$];
        int cnt0;
        logic [3:0] q;
        logic r;

        // Directed cycle-by-cycle table: {rst, req, grant, sel, busy}.
        tbl.push_back(v(1, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(v(0, 4'b0110, 4'b0010, 1, 1));
        tbl.push_back(v(0, 4'b0110, 4'b0010, 1, 1));
        tbl.push_back(v(0, 4'b0100, 4'b0000, 1, 0));
        tbl.push_back(v(0, 4'b0100, 4'b0000, 1, 0));
        tbl.push_back(v(0, 4'b0100, 4'b0100, 2, 1));
        tbl.push_back(v(0, 4'b0000, 4'b0000, 2, 0));
        tbl.push_back(v(0, 4'b0000, 4'b0000, 2, 0));
        tbl.push_back(v(0, 4'b0000, 4'b0000, 2, 0));
        tbl.push_back(v(1, 4'b1111, 4'b0000, 0, 0));
        tbl.push_back(v(0, 4'b1111, 4'b0001, 0, 1));
        tbl.push_back(v(0, 4'b1111, 4'b0001, 0, 1));
        tbl.push_back(v(0, 4'b1111, 4'b0001, 0, 1));
        tbl.push_back(v(0, 4'b1110, 4'b0000, 0, 0));
        tbl.push_back(v(0, 4'b1110, 4'b0000, 0, 0));
        tbl.push_back(v(0, 4'b1111, 4'b0010, 1, 1));
        tbl.push_back(v(0, 4'b1111, 4'b0010, 1, 1));
        tbl.push_back(v(0, 4'b1111, 4'b0010, 1, 1));
        tbl.push_back(v(0, 4'b1101, 4'b0000, 1, 0));
        tbl.push_back(v(0, 4'b1101, 4'b0000, 1, 0));
        tbl.push_back(v(0, 4'b1111, 4'b0100, 2, 1));
        tbl.push_back(v(0, 4'b1111, 4'b0100, 2, 1));
        tbl.push_back(v(0, 4'b1111, 4'b0100, 2, 1));
        tbl.push_back(v(0, 4'b1011, 4'b0000, 2, 0));
        tbl.push_back(v(0, 4'b1011, 4'b0000, 2, 0));
        tbl.push_back(v(0, 4'b1111, 4'b1000, 3, 1));
        tbl.push_back(v(0, 4'b1111, 4'b1000, 3, 1));
        tbl.push_back(v(0, 4'b1111, 4'b1000, 3, 1));
        tbl.push_back(v(1, 4'b1111, 4'b0000, 0, 0));
        tbl.push_back(v(0, 4'b1001, 4'b0001, 0, 1));
        tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(v(0, 4'b1000, 4'b0000, 0, 0));
        tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(v(0, 4'b1000, 4'b1000, 3, 1));
        tbl.push_back(v(0, 4'b0000, 4'b0000, 3, 0));

        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].q);
            chk($sformatf("tbl%0d_grant", i), int'(grant), int'(tbl[i].g));
            chk($sformatf("tbl%0d_sel", i), int'(sel), tbl[i].s);
            chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].b));
        end

        // Two requesters held constantly.
        apply(1, 4'b0011);
`ifdef SPRITE_ARB_BURST_LIMIT_EN
        for (int c = 1; c <= 8; c++) begin
            apply(0, 4'b0011);
            chk($sformatf("burst_c%0d_grant", c), int'(grant), 1);
            chk($sformatf("burst_c%0d_to", c), int'(timeout), 0);
        end
        apply(0, 4'b0011);
        chk("burst_release_grant", int'(grant), 0);
        chk("burst_release_to", int'(timeout), 1);
        apply(0, 4'b0011);
        chk("burst_gap_grant", int'(grant), 0);
        chk("burst_gap_to", int'(timeout), 0);
        apply(0, 4'b0011);
        chk("burst_next_grant", int'(grant), 2);
        chk("burst_next_sel", int'(sel), 1);
`else
        cnt0 = 0;
        for (int c = 1; c <= 20; c++) begin
            apply(0, 4'b0011);
            if (grant == 4'b0001) cnt0++;
        end
        chk("unbounded_hold_cycles", cnt0, 20);
        chk("unbounded_sel", int'(sel), 0);
`endif

        // Randomized run against the reference model.
        apply(1, 4'b0000);
        model_step(1, 4'b0000);
        q = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) < 3) q = 4'($urandom_range(0, 15));
            apply(r, q);
            model_step(r, q);
            chk($sformatf("rnd%0d_grant", c), int'(grant),
                (m_owner >= 0) ? (1 << m_owner) : 0);
            chk($sformatf("rnd%0d_sel", c), int'(sel), m_sel);
            chk($sformatf("rnd%0d_busy", c), int'(busy), (m_owner >= 0) ? 1 : 0);
`ifdef SPRITE_ARB_BURST_LIMIT_EN
            chk($sformatf("rnd%0d_to", c), int'(timeout), int'(m_to));
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
